jt51_op_sched: RTL and testbench
================================

Name: jt51_op_sched

Overview:
- Slot scheduler and configuration store for the jt51 operator pipeline.
- Runs the 32-slot operator sequence: M1 ch0-7, M2 ch0-7, C1 ch0-7, C2 ch0-7.
- Holds each channel's connection (algorithm) and feedback settings, and decodes per-slot modulation-source selects, enter flags, con_I and stage-II-aligned fb_II for the operator datapath.
- Sits between the register interface and the operator block; one instance per chip.

Parameters:
- SLOTS, 32, slots per sample; fixed, only 32 is supported.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cen  input  1  clock enable (P1); all state except the config store advances only when cen=1
- cfg_we  input  1  write strobe for the per-channel config store
- cfg_ch  input  3  channel written
- cfg_con  input  3  connection/algorithm value written
- cfg_fb  input  3  feedback level written
- cnt  output  5  current slot at stage I; cnt[4:3] = operator (0 M1, 1 M2, 2 C1, 3 C2), cnt[2:0] = channel
- zero  output  1  high while cnt==0 (sample start)
- m1_enters, m2_enters, c1_enters, c2_enters  output  1 each  operator type of slot cnt (one-hot)
- con_I  output  3  connection of channel cnt[2:0]
- fb_II  output  3  feedback of the previous slot's channel, registered
- use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y  output  1 each  modulation selects for slot cnt

Behaviour:
- Reset (clk edge with rst=1):
  - cnt=0, fb_II=0, all 8 config entries con=0 and fb=0.
  - After reset, outputs are therefore: zero=1, m1_enters=1, con_I=0, use_prevprev1=1, use_prev1=1, all other selects 0.
- Counter:
  - On cen, cnt <= cnt+1, wrapping 31->0.
  - With cen=0, cnt and fb_II hold.
  - Wrap is free-running; no stop or start control.
- Enter flags: combinational from cnt[4:3], exactly one is high at any time.
- con_I: combinational read of config[cnt[2:0]].con.
- fb_II: on cen, fb_II <= config[cnt[2:0]].fb, so fb_II lines up with the operator's stage II.
- Config writes:
  - On any clk edge with cfg_we=1 and rst=0, independent of cen.
  - A write to the channel currently at cnt changes con_I in the same cycle (combinational read, no bypass needed).
  - fb_II picks up the new value only at the next cen.
  - rst wins over a simultaneous cfg_we.
- Select decode: let a[7:0] = one-hot of con_I.
  - use_prevprev1 = m1_enters | (m2_enters & a[5])
  - use_prev2 = (m2_enters & (a[0]|a[1]|a[2])) | (c2_enters & a[3])
  - use_internal_x = c2_enters & a[2]
  - use_internal_y = c2_enters & (a[0]|a[1]|a[3]|a[4])
  - use_prev1 = m1_enters | (m2_enters & a[1]) | (c1_enters & (a[0]|a[2]|a[5]|a[6])) | (c2_enters & (a[2]|a[5]))
- All select and enter outputs are purely combinational from registered state, so they have no added latency relative to cnt.
- Mid-sequence reset returns to cnt=0 on the next edge and clears config. No partial state persists.

Test Plan:
- Reset, then 32 cen pulses.
  - zero high only at cnt=0; cnt runs 0..31 and back to 0.
  - m1_enters for cnt 0-7, m2 for 8-15, c1 for 16-23, c2 for 24-31.
- cen held 0 for 5 clocks mid-sequence at cnt=13 -> cnt stays 13, fb_II unchanged.
- Write ch3 con=7 fb=5, then step to cnt=27 (C2, ch3).
  - con_I=7 and all five selects are 0.
  - At cnt=3, use_prevprev1=1 and use_prev1=1.
  - fb_II=5 after the cen following cnt=3.
- Write ch2 con=2, then check slot cnt=26 (C2, ch2) -> use_prev1=1, use_internal_x=1, use_internal_y=0, use_prev2=0.
- Write ch1 con=5, then check slot cnt=9 (M2, ch1) -> use_prevprev1=1, use_prev2=0, use_prev1=0.
- Set cfg_we=1 and rst=1 on the same edge for ch0 con=4 -> config[0].con reads back 0, cnt=0.

Source files
------------

// File: rtl/jt51_op_sched.sv
// Slot scheduler and per-channel connection/feedback store for the jt51 operator pipeline.
// Walks the 32-slot M1/M2/C1/C2 x ch0-7 sequence and decodes modulation selects for the current slot.
module jt51_op_sched #(
    parameter int SLOTS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_con,
    input  logic [2:0] cfg_fb,
    output logic [4:0] cnt,
    output logic       zero,
    output logic       m1_enters,
    output logic       m2_enters,
    output logic       c1_enters,
    output logic       c2_enters,
    output logic [2:0] con_I,
    output logic [2:0] fb_II,
    output logic       use_prevprev1,
    output logic       use_prev1,
    output logic       use_prev2,
    output logic       use_internal_x,
    output logic       use_internal_y
);

    logic [4:0] r_cnt;
    logic [2:0] r_fb_ii;
    logic [2:0] r_con [0:7];
    logic [2:0] r_fb  [0:7];

    logic [2:0] w_con_i;
    logic [7:0] w_a;
    logic       w_m1, w_m2, w_c1, w_c2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_fb_ii <= '0;
        end else if (cen) begin
            // fb is read before any same-edge write lands, so it tracks the slot just left
            r_fb_ii <= r_fb[r_cnt[2:0]];
            r_cnt   <= (r_cnt == 5'(SLOTS - 1)) ? 5'd0 : r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_con[i] <= '0;
                r_fb[i]  <= '0;
            end
        end else if (cfg_we) begin
            r_con[cfg_ch] <= cfg_con;
            r_fb[cfg_ch]  <= cfg_fb;
        end
    end

    assign w_con_i = r_con[r_cnt[2:0]];
    assign w_a     = 8'b1 << w_con_i;

    assign w_m1 = (r_cnt[4:3] == 2'd0);
    assign w_m2 = (r_cnt[4:3] == 2'd1);
    assign w_c1 = (r_cnt[4:3] == 2'd2);
    assign w_c2 = (r_cnt[4:3] == 2'd3);

    assign cnt       = r_cnt;
    assign zero      = (r_cnt == 5'd0);
    assign m1_enters = w_m1;
    assign m2_enters = w_m2;
    assign c1_enters = w_c1;
    assign c2_enters = w_c2;
    assign con_I     = w_con_i;
    assign fb_II     = r_fb_ii;

    assign use_prevprev1  = w_m1 | (w_m2 & w_a[5]);
    assign use_prev2      = (w_m2 & (w_a[0] | w_a[1] | w_a[2])) | (w_c2 & w_a[3]);
    assign use_internal_x = w_c2 & w_a[2];
    assign use_internal_y = w_c2 & (w_a[0] | w_a[1] | w_a[3] | w_a[4]);
    assign use_prev1      = w_m1 | (w_m2 & w_a[1])
                          | (w_c1 & (w_a[0] | w_a[2] | w_a[5] | w_a[6]))
                          | (w_c2 & (w_a[2] | w_a[5]));

endmodule

// File: tb/tb_jt51_op_sched.sv
// Self-checking bench for jt51_op_sched: directed scenarios plus random traffic
// compared against a slot/operator-level reference model.
module tb_jt51_op_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0, cfg_con = '0, cfg_fb = '0;
    logic [4:0] cnt;
    logic       zero, m1_enters, m2_enters, c1_enters, c2_enters;
    logic [2:0] con_I, fb_II;
    logic       use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_cnt = 0;
    int m_fb_ii = 0;
    int m_con [8];
    int m_fb  [8];

    jt51_op_sched dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_con(cfg_con), .cfg_fb(cfg_fb),
        .cnt(cnt), .zero(zero),
        .m1_enters(m1_enters), .m2_enters(m2_enters),
        .c1_enters(c1_enters), .c2_enters(c2_enters),
        .con_I(con_I), .fb_II(fb_II),
        .use_prevprev1(use_prevprev1), .use_prev1(use_prev1), .use_prev2(use_prev2),
        .use_internal_x(use_internal_x), .use_internal_y(use_internal_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (slot %0d)", tag, obs, exp, m_cnt);
        end
    endtask

    // Which modulation sources each operator uses under each algorithm.
    function automatic logic [4:0] exp_sel(input int op, input int con);
        logic pp1, p1, p2, ix, iy;
        pp1 = (op == 0) || (op == 1 && con == 5);
        p2  = (op == 1 && con inside {0, 1, 2}) || (op == 3 && con == 3);
        ix  = (op == 3 && con == 2);
        iy  = (op == 3 && con inside {0, 1, 3, 4});
        p1  = (op == 0) || (op == 1 && con == 1)
           || (op == 2 && con inside {0, 2, 5, 6}) || (op == 3 && con inside {2, 5});
        return {pp1, p1, p2, ix, iy};
    endfunction

    task automatic check_all(input string tag);
        int op, ch;
        logic [4:0] s;
        op = m_cnt / 8;
        ch = m_cnt % 8;
        s  = exp_sel(op, m_con[ch]);
        chk({tag, ".cnt"},   int'(cnt), m_cnt);
        chk({tag, ".zero"},  int'(zero), int'(m_cnt == 0));
        chk({tag, ".enters"}, int'({m1_enters, m2_enters, c1_enters, c2_enters}), 8 >> op);
        chk({tag, ".con_I"}, int'(con_I), m_con[ch]);
        chk({tag, ".fb_II"}, int'(fb_II), m_fb_ii);
        chk({tag, ".sel"},
            int'({use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y}), int'(s));
    endtask

    task automatic tick(input logic r, input logic c, input logic we,
                        input int ch, input int con, input int fb, input string tag);
        rst = r; cen = c; cfg_we = we;
        cfg_ch = 3'(ch); cfg_con = 3'(con); cfg_fb = 3'(fb);
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_fb_ii = 0;
            for (int i = 0; i < 8; i++) begin m_con[i] = 0; m_fb[i] = 0; end
        end else begin
            if (c) begin
                m_fb_ii = m_fb[m_cnt % 8];
                m_cnt   = (m_cnt + 1) % 32;
            end
            if (we) begin m_con[ch] = con; m_fb[ch] = fb; end
        end
        #1;
        check_all(tag);
        $display("step %-10s rst=%0d cen=%0d we=%0d cnt=%0d con_I=%0d fb_II=%0d", tag, r, c, we,
                 cnt, con_I, fb_II);
    endtask

    task automatic step_to(input int target, input string tag);
        int n;
        n = 0;
        while (m_cnt != target && n < 64) begin
            tick(1'b0, 1'b1, 1'b0, 0, 0, 0, tag);
            n++;
        end
        chk({tag, ".reach"}, m_cnt, target);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_con[i] = 0; m_fb[i] = 0; end

        // reset state
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0, "reset");
        chk("reset.zero", int'(zero), 1);
        chk("reset.prevprev1", int'(use_prevprev1), 1);
        chk("reset.prev1", int'(use_prev1), 1);

        // one full revolution plus wrap
        for (int i = 0; i < 32; i++) tick(1'b0, 1'b1, 1'b0, 0, 0, 0, "run32");
        chk("wrap.cnt", int'(cnt), 0);

        // cen held low at slot 13
        step_to(13, "to13");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 0, "hold");
        chk("hold.cnt", int'(cnt), 13);

        // ch3 con=7 fb=5
        tick(1'b0, 1'b0, 1'b1, 3, 7, 5, "wr_ch3");
        step_to(27, "to27");
        chk("c2ch3.con_I", int'(con_I), 7);
        chk("c2ch3.sel",
            int'({use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y}), 0);
        step_to(3, "to3");
        chk("m1ch3.prevprev1", int'(use_prevprev1), 1);
        chk("m1ch3.prev1", int'(use_prev1), 1);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 0, "fb_ch3");
        chk("fb_ch3.fb_II", int'(fb_II), 5);

        // ch2 con=2 at C2 slot
        tick(1'b0, 1'b0, 1'b1, 2, 2, 0, "wr_ch2");
        step_to(26, "to26");
        chk("c2ch2.prev1", int'(use_prev1), 1);
        chk("c2ch2.ix", int'(use_internal_x), 1);
        chk("c2ch2.iy", int'(use_internal_y), 0);
        chk("c2ch2.prev2", int'(use_prev2), 0);

        // ch1 con=5 at M2 slot
        tick(1'b0, 1'b0, 1'b1, 1, 5, 0, "wr_ch1");
        step_to(9, "to9");
        chk("m2ch1.prevprev1", int'(use_prevprev1), 1);
        chk("m2ch1.prev2", int'(use_prev2), 0);
        chk("m2ch1.prev1", int'(use_prev1), 0);

        // write to the channel at the current slot shows on con_I immediately
        tick(1'b0, 1'b0, 1'b1, 1, 6, 4, "wr_cur");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), "rand");
            if ($urandom_range(0, 99) == 0) tick(1'b1, 1'b1, 1'b0, 0, 0, 0, "rand_rst");
        end

        // reset beats a simultaneous config write
        step_to(5, "to5");
        tick(1'b1, 1'b1, 1'b1, 0, 4, 6, "rst_we");
        chk("rst_we.cnt", int'(cnt), 0);
        chk("rst_we.con_I", int'(con_I), 0);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 0, "post_rst");
        chk("post_rst.fb_II", int'(fb_II), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
